// File: rtl/fp16_result_serializer.sv
// -----------------------------------------------------------------------------
// fp16_result_serializer
//
// Transmit side of the byte-serial result interface. Completed FP16 result
// words from the multiplier core are buffered in a small FIFO and sent out as
// bytes, low byte first, under a valid/ready handshake towards the pad mux.
// Data is passed through bit-exact (no FP interpretation).
//
// Build option:
//   SER_HEADER_EN  when defined, every word is framed as HDR_BYTE, low byte,
//                  high byte. When undefined, the header state and HDR_BYTE
//                  parameter do not exist and frames are low byte, high byte.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous reset, active-high
//   in_data    in   [WORD_W] result word from the core
//   in_valid   in   in_data is valid
//   in_ready   out  FIFO can accept (push = in_valid & in_ready); 0 during rst
//   out_byte   out  [BYTE_W] current output byte (registered)
//   out_valid  out  out_byte is valid (registered)
//   out_ready  in   sink accepts (pop = out_valid & out_ready)
//   out_last   out  marks the high (final) byte of a word (registered)
//   level      out  [$clog2(DEPTH)+1] FIFO occupancy, excluding the word
//                   currently being shifted out
//   busy       out  a word is being shifted out or the FIFO is non-empty
// -----------------------------------------------------------------------------
module fp16_result_serializer #(
    parameter int WORD_W = 16,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 2
`ifdef SER_HEADER_EN
    ,
    parameter logic [BYTE_W-1:0] HDR_BYTE = 8'hA5
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BYTE_W-1:0]        out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

`ifdef SER_HEADER_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_HDR  = 2'd3
    } state_t;
    // A freshly loaded word starts with its sync byte.
    localparam state_t ST_FIRST = ST_HDR;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;
    localparam state_t ST_FIRST = ST_LO;
`endif

    // FIFO storage and control
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              full;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head;

    // Serializer
    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BYTE_W-1:0] out_byte_q, out_byte_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              byte_pop;

    assign full     = (count_q == LVL_W'(DEPTH));
    // No pass-through when full: a pop on the same edge does not free a slot
    // for the incoming word.
    assign in_ready = ~full & ~rst;
    assign push     = in_valid & in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign byte_pop = out_valid_q & out_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    word_d  = head;
                    state_d = ST_FIRST;
                end
            end
`ifdef SER_HEADER_EN
            ST_HDR: begin
                if (byte_pop) begin
                    state_d = ST_LO;
                end
            end
`endif
            ST_LO: begin
                if (byte_pop) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (byte_pop) begin
                    // Chain straight into the next word to avoid a bubble.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        word_d  = head;
                        state_d = ST_FIRST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they can be registered;
        // during a stall state_d/word_d equal the current values, so the
        // output registers hold.
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        out_byte_d  = '0;
        case (state_d)
            ST_IDLE: out_valid_d = 1'b0;
`ifdef SER_HEADER_EN
            ST_HDR:  out_byte_d = HDR_BYTE;
`endif
            ST_LO:   out_byte_d = word_d[BYTE_W-1:0];
            ST_HI: begin
                out_byte_d = word_d[WORD_W-1:BYTE_W];
                out_last_d = 1'b1;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    // Control state; reset drops any partial word and all FIFO contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Data storage carries no reset; it is only read under valid control.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
        word_q <= word_d;
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign level     = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp16_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_fp16_result_serializer
//
// Drives fp16_result_serializer with directed sequences and random traffic and
// compares every cycle against a byte-stream model: each accepted word becomes
// its frame bytes in a queue; out_valid, level, in_ready and busy are derived
// from how many queued bytes existed before the last clock edge.
// -----------------------------------------------------------------------------
module tb_fp16_result_serializer;

    localparam int DEPTH = 2;
`ifdef SER_HEADER_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [1:0]  level;
    logic        busy;

    always #5 clk = ~clk;

    fp16_result_serializer #(
        .WORD_W(16),
        .BYTE_W(8),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_byte (out_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .level    (level),
        .busy     (busy)
    );

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } ent_t;

    ent_t bq[$];
    bit   pushed_last = 1'b0;

    function automatic ent_t mk(input logic [7:0] b, input logic l);
        ent_t e;
        e.b = b;
        e.l = l;
        return e;
    endfunction

    function automatic int words_in_q();
        return (bq.size() + BPW - 1) / BPW;
    endfunction

    // A byte can be on the port only if it was queued before the last edge.
    function automatic bit exp_valid();
        return (bq.size() - (pushed_last ? BPW : 0)) > 0;
    endfunction

    function automatic int exp_level();
        return words_in_q() - (exp_valid() ? 1 : 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input logic v, input logic [15:0] d, input logic ordy, input logic r);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        do_push   = v && !r && (exp_level() < DEPTH);
        do_pop    = exp_valid() && ordy;
        @(posedge clk);
        if (r) begin
            bq.delete();
            pushed_last = 1'b0;
        end else begin
            if (do_pop) begin
                void'(bq.pop_front());
            end
            if (do_push) begin
`ifdef SER_HEADER_EN
                bq.push_back(mk(8'hA5, 1'b0));
`endif
                bq.push_back(mk(d[7:0], 1'b0));
                bq.push_back(mk(d[15:8], 1'b1));
            end
            pushed_last = do_push;
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_valid()));
        if (exp_valid() && out_valid) begin
            chk("out_byte", 32'(out_byte), 32'(bq[0].b));
            chk("out_last", 32'(out_last), 32'(bq[0].l));
        end
        chk("level", 32'(level), 32'(exp_level()));
        chk("in_ready", 32'(in_ready), 32'((!rst) && (exp_level() < DEPTH)));
        chk("busy", 32'(busy), 32'(bq.size() != 0));
        if (rst) begin
            chk("rst_out_byte", 32'(out_byte), 'h0);
            chk("rst_out_last", 32'(out_last), 'h0);
        end
    endtask

    // In header builds, the byte now on the port must be the sync byte;
    // accept it so the caller continues at the low byte.
    task automatic hdr_skip();
`ifdef SER_HEADER_EN
        chk("hdr_byte", 32'(out_byte), 'hA5);
        chk("hdr_last", 32'(out_last), 'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        // Reset state
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("reset_level", 32'(level), 'h0);
        chk("reset_in_ready", 32'(in_ready), 'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("post_reset_in_ready", 32'(in_ready), 'h1);

        // Single word and latency
        step(1'b1, 16'h4480, 1'b1, 1'b0);
        chk("t1_latency_gap", 32'(out_valid), 'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        hdr_skip();
        chk("t1_lo", 32'(out_byte), 'h80);
        chk("t1_lo_last", 32'(out_last), 'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_hi", 32'(out_byte), 'h44);
        chk("t1_hi_last", 32'(out_last), 'h1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_idle_valid", 32'(out_valid), 'h0);
        chk("t1_idle_busy", 32'(busy), 'h0);

        // Back-to-back words
        step(1'b1, 16'h3C00, 1'b1, 1'b0);
        step(1'b1, 16'hC000, 1'b1, 1'b0);
        hdr_skip();
        chk("t2_b0", 32'(out_byte), 'h00);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_b1", 32'({out_valid, out_byte}), 'h13C);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        hdr_skip();
        chk("t2_b2", 32'({out_valid, out_byte}), 'h100);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_b3", 32'({out_valid, out_last, out_byte}), 'h3C0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Backpressure, full FIFO, refused push
        step(1'b1, 16'h4200, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        hdr_skip();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            chk("t3_hold", 32'({out_valid, out_byte}), 'h100);
        end
        step(1'b1, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        chk("t3_level_full", 32'(level), 'h2);
        chk("t3_in_ready_full", 32'(in_ready), 'h0);
        step(1'b1, 16'h3333, 1'b0, 1'b0);
        chk("t3_refused_level", 32'(level), 'h2);
        // Full with simultaneous pop on the high byte
        step(1'b1, 16'h3333, 1'b1, 1'b0);
        chk("t4_on_hi", 32'({out_last, out_byte}), 'h142);
        step(1'b1, 16'h3333, 1'b1, 1'b0);
        chk("t4_level_after", 32'(level), 'h1);
        chk("t4_in_ready_after", 32'(in_ready), 'h1);
        step(1'b1, 16'h3333, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("t3_drained", 32'(busy), 'h0);

        // Reset mid-word
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        hdr_skip();
        chk("t5_lo", 32'(out_byte), 'h34);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t5_hi_pending", 32'(out_byte), 'h12);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        chk("t5_rst_valid", 32'(out_valid), 'h0);
        chk("t5_rst_level", 32'(level), 'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("t5_no_reemit", 32'(out_valid), 'h0);

        // Random traffic with stall bursts, odd bit patterns and resets
        for (int i = 0; i < 3000; i++) begin
            logic        v;
            logic        o;
            logic        r;
            logic [15:0] d;
            v = ($urandom_range(0, 1) == 1);
            d = 16'($urandom);
            case ($urandom_range(0, 7))
                0: d = 16'h7C00;
                1: d = 16'h7E01;
                2: d = 16'h0001;
                default: ;
            endcase
            if ((i % 200) < 40) begin
                o = ($urandom_range(0, 4) == 0);
            end else begin
                o = ($urandom_range(0, 3) != 0);
            end
            r = ($urandom_range(0, 249) == 0);
            step(v, d, o, r);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("final_idle", 32'({busy, out_valid}), 'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
